// File: rtl/regfile_wb_pkg.sv
// Shared types and helpers for the register-file writeback path:
// queue entry layout and opcode-to-byte-enable decode.
package regfile_wb_pkg;

    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;

    typedef struct packed {
        logic [4:0]  dest;
        logic [31:0] data;
        logic [3:0]  be;
    } wb_entry_t;

    // Partial loads only touch the low lanes; the register file merges by be.
    function automatic logic [3:0] opcode_to_be(input logic [5:0] opcode);
        logic [3:0] be;
        case (opcode)
            OP_LBU:  be = 4'b0001;
            OP_LHU:  be = 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// In-order circular buffer of writeback entries with per-slot valid bits.
// Slot data/enables and the head pointer are exported only when WB_FORWARD_EN is defined.
module wb_fifo
    import regfile_wb_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  wb_entry_t        push_entry,
    input  logic             pop,
    input  logic             flush,
    output wb_entry_t        head_entry,
    output logic [CNT_W-1:0] count,
    output logic [DEPTH-1:0] slot_valid,
    output logic [4:0]       slot_dest [DEPTH]
`ifdef WB_FORWARD_EN
    ,
    output logic [31:0]      slot_data [DEPTH],
    output logic [3:0]       slot_be   [DEPTH],
    output logic [PTR_W-1:0] head_ptr
`endif
);

    wb_entry_t        mem_reg [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic [DEPTH-1:0] slot_valid_reg;

    // Storage carries no reset; slot_valid_reg qualifies every read.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem_reg[wr_ptr_reg] <= push_entry;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_slot
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    slot_valid_reg[gi] <= 1'b0;
                end else if (flush) begin
                    slot_valid_reg[gi] <= 1'b0;
                end else if (push && (wr_ptr_reg == PTR_W'(gi))) begin
                    slot_valid_reg[gi] <= 1'b1;
                end else if (pop && (rd_ptr_reg == PTR_W'(gi))) begin
                    slot_valid_reg[gi] <= 1'b0;
                end
            end

            assign slot_dest[gi] = mem_reg[gi].dest;
`ifdef WB_FORWARD_EN
            assign slot_data[gi] = mem_reg[gi].data;
            assign slot_be[gi]   = mem_reg[gi].be;
`endif
        end
    endgenerate

    assign head_entry = mem_reg[rd_ptr_reg];
    assign count      = count_reg;
    assign slot_valid = slot_valid_reg;
`ifdef WB_FORWARD_EN
    assign head_ptr   = rd_ptr_reg;
`endif

endmodule

// File: rtl/regfile_writeback.sv
// Register-file write initiator: queues results, issues one write per entry in order.
// Optional forwarding lookup (fwd_* ports) is enabled by defining WB_FORWARD_EN.
module regfile_writeback
    import regfile_wb_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_dest,
    input  logic [DATA_W-1:0] in_data,
    input  logic [5:0]        in_opcode,
    input  logic              flush,
    output logic              wr_en,
    input  logic              wr_ready,
    output logic [4:0]        wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [3:0]        wr_be,
    output logic [31:0]       busy_mask
`ifdef WB_FORWARD_EN
    ,
    input  logic [4:0]        fwd_addr,
    output logic              fwd_hit,
    output logic [DATA_W-1:0] fwd_data,
    output logic              fwd_stall
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    wb_entry_t        new_entry;
    wb_entry_t        head_entry;
    wb_entry_t        out_entry_reg;
    logic             out_valid_reg;
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W-1:0] total_count;
    logic [DEPTH-1:0] slot_valid;
    logic [4:0]       slot_dest [DEPTH];
    logic             fifo_empty;
    logic             out_free;
    logic             push_req;
    logic             fifo_push;
    logic             fifo_pop;
`ifdef WB_FORWARD_EN
    logic [31:0]      slot_data [DEPTH];
    logic [3:0]       slot_be   [DEPTH];
    logic [PTR_W-1:0] head_ptr;
`endif

    assign new_entry = '{dest: in_dest, data: in_data, be: opcode_to_be(in_opcode)};

    // Capacity counts the output stage too, so DEPTH results can be outstanding in total.
    assign total_count = fifo_count + CNT_W'(out_valid_reg);
    assign in_ready    = !reset && (total_count < CNT_W'(DEPTH));
    assign push_req    = in_valid && in_ready && (in_dest != 5'd0);
    assign fifo_empty  = (fifo_count == '0);
    assign out_free    = !out_valid_reg || wr_ready;

    // An arrival bypasses the FIFO only when nothing older is waiting for the output stage.
    assign fifo_pop  = !flush && out_free && !fifo_empty;
    assign fifo_push = !flush && push_req && !(out_free && fifo_empty);

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst        (reset),
        .push       (fifo_push),
        .push_entry (new_entry),
        .pop        (fifo_pop),
        .flush      (flush),
        .head_entry (head_entry),
        .count      (fifo_count),
        .slot_valid (slot_valid),
        .slot_dest  (slot_dest)
`ifdef WB_FORWARD_EN
        ,
        .slot_data  (slot_data),
        .slot_be    (slot_be),
        .head_ptr   (head_ptr)
`endif
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_reg <= 1'b0;
            out_entry_reg <= '0;
        end else if (flush) begin
            out_valid_reg <= 1'b0;
        end else if (out_free) begin
            if (!fifo_empty) begin
                out_valid_reg <= 1'b1;
                out_entry_reg <= head_entry;
            end else if (push_req) begin
                out_valid_reg <= 1'b1;
                out_entry_reg <= new_entry;
            end else begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign wr_en   = out_valid_reg;
    assign wr_addr = out_entry_reg.dest;
    assign wr_data = out_entry_reg.data;
    assign wr_be   = out_entry_reg.be;

    logic [31:0] slot_mask [DEPTH];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_mask
            assign slot_mask[gi] = slot_valid[gi] ? (32'd1 << slot_dest[gi]) : 32'd0;
        end
    endgenerate

    always_comb begin
        busy_mask = out_valid_reg ? (32'd1 << out_entry_reg.dest) : 32'd0;
        for (int i = 0; i < DEPTH; i++) begin
            busy_mask = busy_mask | slot_mask[i];
        end
    end

`ifdef WB_FORWARD_EN
    logic             fwd_found;
    logic [31:0]      fwd_match_data;
    logic [3:0]       fwd_match_be;
    logic [PTR_W-1:0] fwd_idx;

    // Walk oldest to youngest so the last match seen is the youngest one.
    always_comb begin
        fwd_found      = 1'b0;
        fwd_match_data = '0;
        fwd_match_be   = '0;
        fwd_idx        = '0;
        if (out_valid_reg && (out_entry_reg.dest == fwd_addr)) begin
            fwd_found      = 1'b1;
            fwd_match_data = out_entry_reg.data;
            fwd_match_be   = out_entry_reg.be;
        end
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx = head_ptr + PTR_W'(i);
            if ((CNT_W'(i) < fifo_count) && (slot_dest[fwd_idx] == fwd_addr)) begin
                fwd_found      = 1'b1;
                fwd_match_data = slot_data[fwd_idx];
                fwd_match_be   = slot_be[fwd_idx];
            end
        end
    end

    assign fwd_hit   = fwd_found && (fwd_addr != 5'd0) && (fwd_match_be == 4'b1111);
    assign fwd_stall = fwd_found && (fwd_addr != 5'd0) && (fwd_match_be != 4'b1111);
    assign fwd_data  = fwd_hit ? fwd_match_data : '0;
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed self-checking bench for regfile_writeback (forwarding steps run when WB_FORWARD_EN is defined).
module tb_regfile_writeback;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_dest;
    logic [31:0] in_data;
    logic [5:0]  in_opcode;
    logic        flush;
    logic        wr_en;
    logic        wr_ready;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;
    logic [31:0] busy_mask;
`ifdef WB_FORWARD_EN
    logic [4:0]  fwd_addr;
    logic        fwd_hit;
    logic [31:0] fwd_data;
    logic        fwd_stall;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regfile_writeback #(.DEPTH(4), .DATA_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_dest   (in_dest),
        .in_data   (in_data),
        .in_opcode (in_opcode),
        .flush     (flush),
        .wr_en     (wr_en),
        .wr_ready  (wr_ready),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_be     (wr_be),
        .busy_mask (busy_mask)
`ifdef WB_FORWARD_EN
        ,
        .fwd_addr  (fwd_addr),
        .fwd_hit   (fwd_hit),
        .fwd_data  (fwd_data),
        .fwd_stall (fwd_stall)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("check %-22s observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [4:0] d, input logic [31:0] v, input logic [5:0] op);
        in_valid  = 1'b1;
        in_dest   = d;
        in_data   = v;
        in_opcode = op;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_dest = '0; in_data = '0; in_opcode = '0;
        flush = 1'b0; wr_ready = 1'b1;
`ifdef WB_FORWARD_EN
        fwd_addr = '0;
`endif
        tick();
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("rst_wr_data", wr_data, 32'd0);
        chk("rst_wr_be", 32'(wr_be), 32'd0);
        chk("rst_busy", busy_mask, 32'd0);
`ifdef WB_FORWARD_EN
        chk("rst_fwd_hit", 32'(fwd_hit), 32'd0);
        chk("rst_fwd_stall", 32'(fwd_stall), 32'd0);
`endif
        tick();
        reset = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Single full-word write, held by wr_ready=0 for two cycles
        wr_ready = 1'b0;
        offer(5'd5, 32'hDEADBEEF, 6'h00);
        tick();
        in_valid = 1'b0;
        chk("t1_wr_en", 32'(wr_en), 32'd1);
        chk("t1_wr_addr", 32'(wr_addr), 32'd5);
        chk("t1_wr_data", wr_data, 32'hDEADBEEF);
        chk("t1_wr_be", 32'(wr_be), 32'hF);
        chk("t1_busy", busy_mask, 32'h20);
        tick();
        chk("t1_hold_addr", 32'(wr_addr), 32'd5);
        chk("t1_hold_busy", busy_mask, 32'h20);
        wr_ready = 1'b1;
        tick();
        chk("t1_done_wr_en", 32'(wr_en), 32'd0);
        chk("t1_done_busy", busy_mask, 32'd0);

        // Partial loads: LBU then LHU back to back
        offer(5'd7, 32'h123456AB, 6'h24);
        tick();
        chk("lbu_be", 32'(wr_be), 32'h1);
        chk("lbu_data", wr_data, 32'h123456AB);
        chk("lbu_addr", 32'(wr_addr), 32'd7);
        offer(5'd8, 32'hCAFE0123, 6'h25);
        tick();
        in_valid = 1'b0;
        chk("lhu_be", 32'(wr_be), 32'h3);
        chk("lhu_addr", 32'(wr_addr), 32'd8);
        chk("lhu_wr_en", 32'(wr_en), 32'd1);
        tick();
        chk("lhu_done_wr_en", 32'(wr_en), 32'd0);

        // Fill the queue while the register file stalls
        wr_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            offer(5'(i), 32'hA0 + 32'(i), 6'h00);
            tick();
        end
        offer(5'd10, 32'hBAD, 6'h00);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        chk("full_busy", busy_mask, 32'h1E);
        tick();
        in_valid = 1'b0;
        chk("full_hold_addr", 32'(wr_addr), 32'd1);
        chk("full_hold_data", wr_data, 32'hA1);
        chk("full_busy_no10", busy_mask, 32'h1E);
        wr_ready = 1'b1;
        #1;
        chk("full_deq_in_ready", 32'(in_ready), 32'd0);
        for (int i = 2; i <= 4; i++) begin
            tick();
            chk("drain_addr", 32'(wr_addr), 32'(i));
            chk("drain_data", wr_data, 32'hA0 + 32'(i));
        end
        chk("drain_in_ready", 32'(in_ready), 32'd1);
        tick();
        chk("drain_done_wr_en", 32'(wr_en), 32'd0);
        chk("drain_done_busy", busy_mask, 32'd0);

        // Destination zero is accepted and dropped
        offer(5'd0, 32'h12345678, 6'h00);
        #1;
        chk("x0_in_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        chk("x0_wr_en", 32'(wr_en), 32'd0);
        chk("x0_busy", busy_mask, 32'd0);

        // Flush with a simultaneous offer
        wr_ready = 1'b0;
        offer(5'd11, 32'h11, 6'h00); tick();
        offer(5'd12, 32'h12, 6'h00); tick();
        offer(5'd13, 32'h13, 6'h00); tick();
        chk("pre_flush_busy", busy_mask, 32'h3800);
        offer(5'd14, 32'h14, 6'h00);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_wr_en", 32'(wr_en), 32'd0);
        chk("flush_busy", busy_mask, 32'd0);
        wr_ready = 1'b1;
        tick();
        chk("flush_no_new_wr_en", 32'(wr_en), 32'd0);

        // Asynchronous reset mid-operation
        wr_ready = 1'b0;
        offer(5'd6, 32'h66, 6'h00);
        tick();
        in_valid = 1'b0;
        chk("mid_pre_wr_en", 32'(wr_en), 32'd1);
        reset = 1'b1;
        #1;
        chk("mid_rst_wr_en", 32'(wr_en), 32'd0);
        chk("mid_rst_busy", busy_mask, 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
        tick();
        reset = 1'b0;
        tick();
        chk("mid_after_wr_en", 32'(wr_en), 32'd0);

`ifdef WB_FORWARD_EN
        wr_ready = 1'b0;
        fwd_addr = 5'd9;
        offer(5'd9, 32'h1, 6'h00);
        tick();
        chk("fwd_full_hit", 32'(fwd_hit), 32'd1);
        chk("fwd_full_data", fwd_data, 32'h1);
        chk("fwd_full_stall", 32'(fwd_stall), 32'd0);
        offer(5'd9, 32'h55, 6'h24);
        tick();
        in_valid = 1'b0;
        chk("fwd_part_hit", 32'(fwd_hit), 32'd0);
        chk("fwd_part_stall", 32'(fwd_stall), 32'd1);
        fwd_addr = 5'd0;
        #1;
        chk("fwd_x0_stall", 32'(fwd_stall), 32'd0);
        fwd_addr = 5'd9;
        wr_ready = 1'b1;
        tick();
        chk("fwd_one_ack_stall", 32'(fwd_stall), 32'd1);
        tick();
        chk("fwd_drained_hit", 32'(fwd_hit), 32'd0);
        chk("fwd_drained_stall", 32'(fwd_stall), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/regfile_writeback.md
# regfile_writeback

Write-side initiator for the 32x32 register file. Accepts completed results (ALU or load path) through a valid/ready handshake and buffers them in a small in-order queue. Issues exactly one register-file write per accepted result, with byte enables for partial loads, and exports a pending-destination bitmap for hazard detection. Sits between the execute/memory stages and the register file's write port.

## Interface
- DEPTH, 4, queue entries (power of two, 2..16)
- DATA_W, 32, result/register width (fixed 32 in this design)
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- in_valid  in  1  result offered
- in_ready  out  1  queue can accept
- in_dest  in  5  destination register number
- in_data  in  32  result word
- in_opcode  in  6  producing instruction's opcode (selects byte enables)
- flush  in  1  discard all queued, not-yet-written entries
- wr_en  out  1  register-file write request
- wr_ready  in  1  register file accepts the write this cycle
- wr_addr  out  5  write register number
- wr_data  out  32  write data
- wr_be  out  4  byte enables, bit i = data[8i+7:8i]
- busy_mask  out  32  bit r set while any queued or issuing entry targets r
- fwd_addr  in  5  forwarding lookup address (WB_FORWARD_EN only)
- fwd_hit  out  1  full-word pending value available (WB_FORWARD_EN only)
- fwd_data  out  32  that value (WB_FORWARD_EN only)
- fwd_stall  out  1  youngest match is partial; consumer must stall (WB_FORWARD_EN only)

## Operation
- Enqueue on in_valid && in_ready; in_ready = !reset && count < DEPTH (no same-cycle full bypass).
- in_dest == 0: handshake completes, entry is dropped, no write issued, busy_mask unaffected.
- Byte enables from in_opcode: 6'h24 -> 4'b0001; 6'h25 -> 4'b0011; anything else -> 4'b1111. Data passes through unmodified; the register file merges by wr_be.
- Head entry drives wr_en/wr_addr/wr_data/wr_be from a registered output stage; outputs hold stable while wr_en && !wr_ready.
- Dequeue on wr_en && wr_ready; next entry, if any, is presented the following cycle (one write per cycle sustained).
- Strict in-order: writes leave in acceptance order, including repeated destinations.
- busy_mask = OR of one-hot(dest) over all valid entries including the output stage; recomputed combinationally from stored state.
- flush: all entries and the output stage invalidated at the clock edge; flush wins over same-cycle enqueue and dequeue; a write handshaken in the same cycle as flush still counts as performed.

## Timing
- Reset values: wr_en 0, wr_addr 0, wr_data 0, wr_be 0, busy_mask 0, in_ready 0 while reset high, 1 on first cycle after release; fwd_hit/fwd_stall 0, fwd_data 0.
- Latency: accepted at edge N into empty queue -> wr_en high during cycle N+1.
- busy_mask bit sets in the cycle after acceptance; clears in the cycle after the last matching write handshakes.
- Full with simultaneous dequeue: in_ready stays 0 that cycle; rises next cycle.
- Reset asserted mid-operation: queue emptied immediately (asynchronous); in-flight write abandoned.
- Pointers wrap modulo DEPTH; count is log2(DEPTH)+1 bits.

## Configuration
- WB_FORWARD_EN defined: fwd_* ports present; combinational lookup of youngest valid entry with dest == fwd_addr (fwd_addr 0 never hits); full-word match -> fwd_hit 1 + its data; partial match -> fwd_hit 0, fwd_stall 1; no match -> both 0.
- Undefined: fwd_* ports and lookup logic absent; all other behaviour identical.

## Structure
- Package regfile_wb_pkg: OP_LBU = 6'h24, OP_LHU = 6'h25, wb_entry_t struct (dest, data, be), function opcode_to_be.
- Sub-module wb_fifo: parameterised DEPTH circular buffer of wb_entry_t with push/pop/flush, count, and per-entry valid vector exposed for busy_mask and forwarding.

## Test plan
- Reset, then in_dest=5, data=32'hDEADBEEF, opcode=0 -> next cycle wr_en=1, wr_addr=5, wr_be=4'b1111; busy_mask=32'h20 until ack.
- Opcode 6'h24, data=32'h123456AB, dest=7 -> wr_be=4'b0001, wr_data=32'h123456AB; opcode 6'h25 -> wr_be=4'b0011.
- wr_ready held 0, push 4 entries -> in_ready=0 on 5th offer, outputs stable; release wr_ready -> 4 writes in order on consecutive cycles.
- in_dest=0 accepted -> no wr_en, busy_mask stays 0.
- 3 queued entries, flush with simultaneous in_valid -> next cycle wr_en=0, busy_mask=0, new entry not queued.
- WB_FORWARD_EN: queue dest 9 full-word 32'h1 then dest 9 via 6'h24 -> fwd_addr=9 gives fwd_hit=0, fwd_stall=1; after second write acks -> fwd_hit=0, fwd_stall=0.
